// File: rtl/present_key_schedule.sv
// PRESENT key register and round-key generator for PRESENT-80 / PRESENT-128.
// The key width is fixed at elaboration; round_key is the top 64 bits of the register.
module present_key_schedule #(
  parameter int KEY_WIDTH = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 step,
  input  logic [4:0]           round_ctr,
  output logic [63:0]          round_key,
  output logic                 key_valid
);

  logic [KEY_WIDTH-1:0] key_reg;
  logic [KEY_WIDTH-1:0] rotated;
  logic [KEY_WIDTH-1:0] next_key;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Per-width round update: rotate left by 61, S-box the top nibble(s), fold in the counter.
  generate
    if (KEY_WIDTH == 80) begin : g_key80
      assign rotated = {key_reg[18:0], key_reg[79:19]};
      always_comb begin
        next_key         = rotated;
        next_key[79:76]  = sbox(rotated[79:76]);
        next_key[19:15]  = rotated[19:15] ^ round_ctr;
      end
    end else if (KEY_WIDTH == 128) begin : g_key128
      assign rotated = {key_reg[66:0], key_reg[127:67]};
      always_comb begin
        next_key           = rotated;
        next_key[127:124]  = sbox(rotated[127:124]);
        next_key[123:120]  = sbox(rotated[123:120]);
        next_key[66:62]    = rotated[66:62] ^ round_ctr;
      end
    end else begin : g_bad_width
      $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
    end
  endgenerate

  // Reset beats load, load beats step, and steps need a valid key to act on.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg   <= '0;
      key_valid <= 1'b0;
    end else if (key_load) begin
      key_reg   <= key_in;
      key_valid <= 1'b1;
    end else if (step && key_valid) begin
      key_reg   <= next_key;
    end
  end

  assign round_key = key_reg[KEY_WIDTH-1 -: 64];

endmodule

// File: tb/tb_present_key_schedule.sv
// Directed bench for present_key_schedule, both key widths instantiated side by side.
// Round keys are checked against hand values, a bit-level model and known PRESENT ciphertexts.
module tb_present_key_schedule;

  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic         step;
  logic [4:0]   round_ctr;
  logic [79:0]  key80;
  logic [127:0] key128;
  logic [63:0]  rk80;
  logic [63:0]  rk128;
  logic         valid80;
  logic         valid128;

  int checkCount = 0;
  int errorCount = 0;

  logic [63:0]  roundKeys [32];
  logic [79:0]  model80;
  logic [127:0] model128;
  logic [63:0]  heldKey;

  always #5 clk = ~clk;

  present_key_schedule #(.KEY_WIDTH(80)) dut80 (
    .clk(clk), .reset(reset), .key_load(key_load), .key_in(key80),
    .step(step), .round_ctr(round_ctr), .round_key(rk80), .key_valid(valid80)
  );

  present_key_schedule #(.KEY_WIDTH(128)) dut128 (
    .clk(clk), .reset(reset), .key_load(key_load), .key_in(key128),
    .step(step), .round_ctr(round_ctr), .round_key(rk128), .key_valid(valid128)
  );

  function automatic logic [3:0] sboxLookup(input logic [3:0] x);
    logic [63:0] table64;
    table64 = SBOX_TABLE;
    return table64[4*x +: 4];
  endfunction

  function automatic logic [79:0] update80(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] n;
    for (int j = 0; j < 80; j++) n[j] = k[(j + 19) % 80];
    n[79:76] = sboxLookup(n[79:76]);
    n[19:15] = n[19:15] ^ rc;
    return n;
  endfunction

  function automatic logic [127:0] update128(input logic [127:0] k, input logic [4:0] rc);
    logic [127:0] n;
    for (int j = 0; j < 128; j++) n[j] = k[(j + 67) % 128];
    n[127:124] = sboxLookup(n[127:124]);
    n[123:120] = sboxLookup(n[123:120]);
    n[66:62]   = n[66:62] ^ rc;
    return n;
  endfunction

  // Full PRESENT encryption of pt using the captured round keys K1..K32.
  function automatic logic [63:0] encrypt(input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] p;
    s = pt;
    for (int r = 0; r < 31; r++) begin
      s = s ^ roundKeys[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sboxLookup(s[4*n +: 4]);
      for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : ((b * 16) % 63)] = s[b];
      s = p;
    end
    return s ^ roundKeys[31];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic st, input logic [4:0] rc);
    reset     = rst;
    key_load  = ld;
    step      = st;
    round_ctr = rc;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    key_load  = 1'b0;
    step      = 1'b0;
    round_ctr = 5'd0;
  endtask

  task automatic runSchedule80(input logic [79:0] k);
    key80   = k;
    model80 = k;
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("k80 load", rk80, model80[79:16]);
    roundKeys[0] = rk80;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 5'(i));
      model80 = update80(model80, 5'(i));
      checkOutput($sformatf("k80 round %0d", i + 1), rk80, model80[79:16]);
      roundKeys[i] = rk80;
    end
  endtask

  task automatic runSchedule128(input logic [127:0] k);
    key128   = k;
    model128 = k;
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("k128 load", rk128, model128[127:64]);
    roundKeys[0] = rk128;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 5'(i));
      model128 = update128(model128, 5'(i));
      checkOutput($sformatf("k128 round %0d", i + 1), rk128, model128[127:64]);
      roundKeys[i] = rk128;
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_load  = 1'b0;
    step      = 1'b0;
    round_ctr = 5'd0;
    key80     = 80'h1234_5678_9ABC_DEF0_1357;
    key128    = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    @(negedge clk);

    // Reset must win over a simultaneous load.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    checkOutput("reset rk80", rk80, 64'h0);
    checkOutput("reset valid80", {63'h0, valid80}, 64'h0);
    checkOutput("reset rk128", rk128, 64'h0);
    checkOutput("reset valid128", {63'h0, valid128}, 64'h0);

    // A step without a loaded key is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd1);
    checkOutput("step invalid rk80", rk80, 64'h0);
    checkOutput("step invalid rk128", rk128, 64'h0);

    // Zero key, hand-derived first updates.
    key80  = 80'h0;
    key128 = 128'h0;
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("zero load rk80", rk80, 64'h0);
    checkOutput("zero load valid80", {63'h0, valid80}, 64'h1);
    checkOutput("zero load valid128", {63'h0, valid128}, 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd1);
    checkOutput("zero step1 rk80", rk80, 64'hC000000000000000);
    checkOutput("zero step1 rk128", rk128, 64'hCC00000000000000);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd2);
    checkOutput("zero step2 rk80", rk80, 64'h5000180000000001);

    // Full schedules, confirmed through known-answer encryptions.
    runSchedule80(80'h0);
    checkOutput("ct80 zero key", encrypt(64'h0), 64'h5579C1387B228445);
    runSchedule80({80{1'b1}});
    checkOutput("ct80 ones key", encrypt(64'h0), 64'hE72C46C0F5945049);
    runSchedule128(128'h0);
    checkOutput("ct128 zero key", encrypt(64'h0), 64'h96DB702A2E6900AF);
    runSchedule128(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // Load and step together: load wins, no update applied.
    key80  = 80'hA5A5_5A5A_C3C3_3C3C_9696;
    key128 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd7);
    checkOutput("priority rk80", rk80, 64'hA5A5_5A5A_C3C3_3C3C);
    checkOutput("priority rk128", rk128, 64'h1111_2222_3333_4444);

    // Hold mid-schedule; key_in changes must not leak in without a load.
    model80 = key80;
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 5'(i));
      model80 = update80(model80, 5'(i));
      checkOutput($sformatf("pre-hold round %0d", i + 1), rk80, model80[79:16]);
    end
    heldKey = model80[79:16];
    for (int i = 0; i < 5; i++) begin
      key80 = 80'(i + 1) * 80'h1111_1111_1111;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'(i + 9));
      checkOutput($sformatf("hold cycle %0d", i), rk80, heldKey);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd3);
    model80 = update80(model80, 5'd3);
    checkOutput("post-hold round 4", rk80, model80[79:16]);

    // Counter wrap value 0 and continued stepping.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd0);
    model80 = update80(model80, 5'd0);
    checkOutput("rc zero step", rk80, model80[79:16]);

    // Reset mid-schedule clears the key and blocks further steps.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5);
    checkOutput("midreset rk80", rk80, 64'h0);
    checkOutput("midreset valid80", {63'h0, valid80}, 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd6);
    checkOutput("midreset step rk80", rk80, 64'h0);
    checkOutput("midreset step rk128", rk128, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
